// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_e;

  localparam int unsigned N_ROWS = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 8;

  // Reflected binary Gray code of a 3-bit row index.
  function automatic logic [IDX_W-1:0] gray3(input logic [IDX_W-1:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

// File: rtl/tt_vec_gen.sv
// Row index to gate input vector mapping.
// Build option: TT_SWEEP_GRAY_EN selects Gray ordering instead of binary.
module tt_vec_gen
  import tt_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic [IDX_W-1:0] vec_o
);

`ifdef TT_SWEEP_GRAY_EN
  assign vec_o = gray3(idx_i);
`else
  assign vec_o = idx_i;
`endif

endmodule

// File: rtl/tt_sweep.sv
// Sequential truth-table characterizer for a 3-input combinational gate.
// Build option: TT_SWEEP_GRAY_EN applies the vectors in Gray order.
module tt_sweep
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'hCC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match
);

  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     vec_q;
  logic [N_ROWS-1:0]    table_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 match_q;

  logic [IDX_W-1:0]     idx_nxt;
  logic [IDX_W-1:0]     vec_nxt;
  logic [N_ROWS-1:0]    table_smp_c;
  logic                 last_c;

  assign idx_nxt = idx_q + IDX_W'(1);
  assign last_c  = (cnt_q == CNT_W'(SETTLE_CYCLES));

  // Vector for the row that follows the one currently applied.
  tt_vec_gen u_vec_gen (
    .idx_i (idx_nxt),
    .vec_o (vec_nxt)
  );

  // Table with the current sample merged in; row 000 lands in the MSB.
  always_comb begin
    table_smp_c          = table_q;
    table_smp_c[~vec_q]  = dut_out;
  end

  // Sweep FSM, settle counter and captured table.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= APPLY;
            idx_q   <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            table_q <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        APPLY: begin
          if (last_c) begin
            table_q <= table_smp_c;
            if (idx_q == IDX_W'(N_ROWS - 1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              vec_q   <= '0;
              match_q <= (table_smp_c == EXPECTED);
            end else begin
              idx_q <= idx_nxt;
              cnt_q <= '0;
              vec_q <= vec_nxt;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          vec_q   <= '0;
        end
      endcase
    end
  end

  assign {in1, in2, in3} = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign table_out       = table_q;
  assign match           = match_q;

endmodule

// File: tb/tb_tt_sweep.sv
// Directed bench for tt_sweep: default instance (settle 2) and a settle-0 instance.
module tb_tt_sweep;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b;
  logic [1:0] gate_mode;   // 0: ~in2, 1: in1&in2&in3, 2: constant 1

  logic a_in1, a_in2, a_in3, a_busy, a_done, a_match, a_out;
  logic b_in1, b_in2, b_in3, b_busy, b_done, b_match, b_out;
  logic [7:0] a_table, b_table;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] seq [8];

  always #5 clk = ~clk;

  // Gate models driven from each sweeper's vector outputs.
  always_comb begin
    case (gate_mode)
      2'd0:    a_out = ~a_in2;
      2'd1:    a_out = a_in1 & a_in2 & a_in3;
      default: a_out = 1'b1;
    endcase
    case (gate_mode)
      2'd0:    b_out = ~b_in2;
      2'd1:    b_out = b_in1 & b_in2 & b_in3;
      default: b_out = 1'b1;
    endcase
  end

  tt_sweep u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(a_out),
    .in1(a_in1), .in2(a_in2), .in3(a_in3), .busy(a_busy), .done(a_done),
    .table_out(a_table), .match(a_match)
  );

  tt_sweep #(.SETTLE_CYCLES(0), .EXPECTED(8'hCC)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(b_out),
    .in1(b_in1), .in2(b_in2), .in3(b_in3), .busy(b_busy), .done(b_done),
    .table_out(b_table), .match(b_match)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on instance A; returns in cycle 1 of the sweep.
  task automatic kick_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1;
    tick(); tick();
    start_a = 1'b0; start_b = 1'b0;
    n_vec++;
    if ({a_in1, a_in2, a_in3, a_busy, a_done, a_match, a_table} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_a: got in=%b%b%b busy=%b done=%b match=%b table=%h, want all zero",
               a_in1, a_in2, a_in3, a_busy, a_done, a_match, a_table);
    end
    n_vec++;
    if ({b_in1, b_in2, b_in3, b_busy, b_done, b_match, b_table} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_b: got busy=%b done=%b table=%h, want all zero", b_busy, b_done, b_table);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_not_in2();
    logic [2:0] v_exp;
    gate_mode = 2'd0;
    kick_a();
    for (int c = 1; c <= 26; c++) begin
      v_exp = (c <= 24) ? seq[(c - 1) / 3] : 3'd0;
      n_vec++;
      if (a_busy !== (c <= 24) || a_done !== (c == 25) || {a_in1, a_in2, a_in3} !== v_exp) begin
        n_err++;
        $display("FAIL not_in2_c%0d: busy=%b done=%b vec=%b, want busy=%b done=%b vec=%b",
                 c, a_busy, a_done, {a_in1, a_in2, a_in3}, (c <= 24), (c == 25), v_exp);
      end
      if (c == 25) begin
        n_vec++;
        if (a_table !== 8'hCC || a_match !== 1'b1) begin
          n_err++;
          $display("FAIL not_in2_table: table=%h match=%b, want cc 1", a_table, a_match);
        end
      end
      tick();
    end
    n_vec++;
    if (a_table !== 8'hCC || a_match !== 1'b1) begin
      n_err++;
      $display("FAIL not_in2_hold: table=%h match=%b, want cc 1", a_table, a_match);
    end
  endtask

  task automatic test_and_then_ones();
    gate_mode = 2'd1;
    kick_a();
    repeat (24) tick();
    n_vec++;
    if (a_done !== 1'b1 || a_table !== 8'h01 || a_match !== 1'b0) begin
      n_err++;
      $display("FAIL and3: done=%b table=%h match=%b, want 1 01 0", a_done, a_table, a_match);
    end
    tick();
    gate_mode = 2'd2;
    kick_a();
    n_vec++;
    if (a_table !== 8'h00 || a_match !== 1'b0) begin
      n_err++;
      $display("FAIL ones_clear: table=%h match=%b, want 00 0", a_table, a_match);
    end
    repeat (24) tick();
    n_vec++;
    if (a_done !== 1'b1 || a_table !== 8'hFF || a_match !== 1'b0) begin
      n_err++;
      $display("FAIL ones: done=%b table=%h match=%b, want 1 ff 0", a_done, a_table, a_match);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int n_done = 0;
    gate_mode = 2'd0;
    kick_a();
    for (int c = 1; c <= 40; c++) begin
      if (a_done === 1'b1) n_done++;
      n_vec++;
      if (a_busy !== (c <= 24)) begin
        n_err++;
        $display("FAIL ignore_busy_c%0d: busy=%b, want %b", c, a_busy, (c <= 24));
      end
      start_a = (c == 5 || c == 25);
      tick();
    end
    start_a = 1'b0;
    n_vec++;
    if (n_done != 1) begin
      n_err++;
      $display("FAIL ignore_done_count: got %0d pulses, want 1", n_done);
    end
  endtask

  task automatic test_reset_mid();
    gate_mode = 2'd0;
    kick_a();
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++;
    if ({a_in1, a_in2, a_in3, a_busy, a_done, a_match, a_table} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b match=%b table=%h vec=%b, want all zero",
               a_busy, a_done, a_match, a_table, {a_in1, a_in2, a_in3});
    end
    tick();
    kick_a();
    repeat (24) tick();
    n_vec++;
    if (a_done !== 1'b1 || a_table !== 8'hCC || a_match !== 1'b1) begin
      n_err++;
      $display("FAIL reset_restart: done=%b table=%h match=%b, want 1 cc 1", a_done, a_table, a_match);
    end
    tick();
  endtask

  task automatic test_settle0();
    gate_mode = 2'd0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      n_vec++;
      if (b_busy !== (c <= 8) || b_done !== (c == 9) ||
          {b_in1, b_in2, b_in3} !== ((c <= 8) ? seq[c - 1] : 3'd0)) begin
        n_err++;
        $display("FAIL settle0_c%0d: busy=%b done=%b vec=%b", c, b_busy, b_done, {b_in1, b_in2, b_in3});
      end
      if (c == 9) begin
        n_vec++;
        if (b_table !== 8'hCC || b_match !== 1'b1) begin
          n_err++;
          $display("FAIL settle0_table: table=%h match=%b, want cc 1", b_table, b_match);
        end
      end
      tick();
    end
  endtask

  initial begin
`ifdef TT_SWEEP_GRAY_EN
    seq[0] = 3'b000; seq[1] = 3'b001; seq[2] = 3'b011; seq[3] = 3'b010;
    seq[4] = 3'b110; seq[5] = 3'b111; seq[6] = 3'b101; seq[7] = 3'b100;
`else
    for (int i = 0; i < 8; i++) seq[i] = 3'(i);
`endif
    gate_mode = 2'd0;
    start_a = 1'b0;
    start_b = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_not_in2();
    test_and_then_ones();
    test_ignore_start();
    test_reset_mid();
    test_settle0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
